// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package down_counter_timer_pkg;

    // Default counter width.
    localparam int DEFAULT_WIDTH = 4;

    // The terminal-count output is a single-cycle pulse.
    localparam int TC_PULSE_LEN = 1;

    // IDLE: stopped or paused, RUN: counting, DONE: reached zero without reload.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer_if.sv
// Control and status bundle of the down-counter/timer.
// Latency: n/a (wiring only).
// Backpressure: none; control inputs are sampled every cycle.
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             ce;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    // Controller side: drives commands, observes status.
    modport master (
        output load, load_val, start, stop, ce, auto_reload,
        input  count, tc, busy, done
    );

    // Timer side: receives commands, reports status.
    modport slave (
        input  load, load_val, start, stop, ce, auto_reload,
        output count, tc, busy, done
    );
endinterface : down_counter_timer_if

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload.
// Latency: all outputs registered; commands take effect on the next rising edge.
// Backpressure: none; start in RUN and stop outside RUN are ignored.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    down_counter_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] W_ZERO = '0;
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;

    // Next state and datapath; priority is load > stop (RUN) > start > ce.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (bus.load) begin
            w_count_nxt  = bus.load_val;
            w_reload_nxt = bus.load_val;
            w_state_nxt  = ST_IDLE;
        end else if (r_state == ST_RUN && bus.stop) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state != ST_RUN && bus.start) begin
            // Starting from zero is an immediate terminal event.
            if (r_count != W_ZERO) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_DONE;
                w_tc_nxt    = 1'b1;
            end
        end else if (r_state == ST_RUN && bus.ce) begin
            if (r_count > W_ONE) begin
                w_count_nxt = r_count - W_ONE;
            end else if (bus.auto_reload && r_reload != W_ZERO) begin
                // Reload instead of showing zero, so the period stays exact.
                w_count_nxt = r_reload;
                w_tc_nxt    = 1'b1;
            end else begin
                w_count_nxt = W_ZERO;
                w_state_nxt = ST_DONE;
                w_tc_nxt    = 1'b1;
            end
        end
    end

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= W_ZERO;
            r_reload <= W_ZERO;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule : down_counter_timer

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Synchronous, loadable, WIDTH-bit down-counter/timer: the counting-down counterpart to the team's ripple up-counter.
- Counts a programmed value down to zero on qualified tick cycles and flags terminal count; optionally auto-reloads for periodic ticks.
- Single clock domain; feeds interval/timeout logic alongside the existing counter chain.

Parameters:
WIDTH, 4, bit width of count and load value

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  load load_val into count and reload register; aborts any run
load_val  input  WIDTH  value captured when load=1
start  input  1  begin counting from current count
stop  input  1  pause counting, hold count
ce  input  1  count enable (tick qualifier), only meaningful in RUN
auto_reload  input  1  1: reload and continue at terminal count; 0: stop at zero
count  output  WIDTH  current counter value (registered)
tc  output  1  terminal-count pulse, one cycle, registered
busy  output  1  high while in RUN
done  output  1  high while in DONE

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset. reset is sampled only on the rising clk edge.
- Reset (highest priority): state=IDLE, count=0, reload_reg=0, tc=0, busy=0, done=0. All other inputs are ignored in that cycle.
- FSM states:
  - IDLE: stopped or paused.
  - RUN: counting.
  - DONE: reached zero without reload.
- Outputs: busy = (state==RUN); done = (state==DONE); both are registered state decodes.
- Input priority per cycle: reset > load > stop (RUN only) > start > ce.
- load (any state): count<=load_val, reload_reg<=load_val, state<=IDLE, tc<=0.
- start in IDLE or DONE:
  - If count!=0: state<=RUN. No decrement in the start cycle; the first decrement is possible the following cycle.
  - If count==0: state<=DONE, tc<=1 for one cycle.
- start in RUN: ignored.
- stop in RUN: state<=IDLE, count held, no tc. stop in IDLE/DONE: ignored.
- start and stop together: in RUN, stop wins; in IDLE/DONE, start acts.
- RUN with ce=1:
  - count>1: count<=count-1.
  - count==1 and (auto_reload=0 or reload_reg==0): count<=0, state<=DONE, tc<=1.
  - count==1 and auto_reload=1 and reload_reg!=0: count<=reload_reg, remain RUN, tc<=1.
- RUN with ce=0: count held.
- tc: high exactly one cycle per terminal event, in the same cycle count shows 0 (or the reloaded value). Otherwise 0.
- No underflow: count never wraps below 0.
- auto_reload is sampled at the terminal step only.
- Reset mid-operation: next cycle matches the reset values exactly. No tc is emitted.
- Maximum period: load_val = 2^WIDTH-1 gives tc after 2^WIDTH-1 ce-qualified cycles.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, RUN, DONE);
  - DEFAULT_WIDTH=4 constant;
  - TC_PULSE_LEN=1 documentation constant.
- Single module: the FSM and datapath are too small to justify a sub-module.

Test Plan:
- reset, load_val=5, start, ce=1 continuous -> count 5,4,3,2,1,0 on successive cycles after start; tc=1 only in the count=0 cycle; then done=1, busy=0.
- auto_reload=1, load 3, start, ce=1 -> count 3,2,1,3,2,1,3; tc pulses each time count shows 3 after 1; busy stays 1, done stays 0.
- load 6, start, ce alternating 1/0, stop asserted when count=2 -> count holds 2, busy=0; start again -> decrements resume only on ce=1 cycles, tc at 0.
- load 4, start, after two decrements (count=2) load_val=9 with load=1 -> next cycle count=9, busy=0, tc=0; start and stop together in that IDLE state -> RUN entered.
- reset asserted while RUN at count=3 together with start=1 -> next cycle count=0, tc=0, busy=0, done=0.
- after reset, start with count=0 -> next cycle tc=1 for one cycle, done=1. Then load_val=15 (WIDTH=4) and start -> tc after exactly 15 ce cycles.
